// File: rtl/keypad_entry.sv
// keypad_entry: scans a 4x4 active-low matrix keypad, debounces press and
// release, strobes key_valid once per accepted press, and assembles up to
// four decimal digits into a 16-bit BCD code word (newest digit in [3:0]).
// Optional build macro: KEYPAD_AUTO_REPEAT_EN -- a held key re-strobes every
// REPEAT_CNT cycles and each repeat feeds the entry buffer like a new press.
module keypad_entry #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000,
  parameter int REPEAT_CNT   = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  input  logic        clear,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] code,
  output logic [2:0]  digit_cnt,
  output logic        code_full
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam int RW = $clog2(REPEAT_CNT + 1);

`ifdef KEYPAD_AUTO_REPEAT_EN
  localparam logic REPEAT_ON = 1'b1;
`else
  localparam logic REPEAT_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [1:0]      ridx_r, ridx_s;
  logic [DW-1:0]   dwell_r, dwell_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [RW-1:0]   rep_r, rep_s;
  logic [3:0]      lcol_r, lcol_s;
  logic [3:0]      row_r;
  logic            key_valid_r, key_valid_s;
  logic [3:0]      key_code_r, key_code_s;
  logic [15:0]     code_r, code_s;
  logic [2:0]      digit_cnt_r, digit_cnt_s;
  logic            code_full_r;

  // True when exactly one column line is pulled low.
  function automatic logic single_low(input logic [3:0] c);
    logic hit;
    case (c)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
      default:                            hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Column index of the single low bit (only meaningful when single_low).
  function automatic logic [1:0] low_pos(input logic [3:0] c);
    logic [1:0] pos;
    case (c)
      4'b1110: pos = 2'd0;
      4'b1101: pos = 2'd1;
      4'b1011: pos = 2'd2;
      4'b0111: pos = 2'd3;
      default: pos = 2'd0;
    endcase
    return pos;
  endfunction

  // Physical key position to key code.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  4'hF: k = 4'hD;
      default: k = 4'h0;
    endcase
    return k;
  endfunction

  // Scan / debounce / hold / release next-state and strobe generation.
  always_comb begin
    state_s     = state_r;
    ridx_s      = ridx_r;
    dwell_s     = dwell_r;
    cnt_s       = cnt_r;
    rep_s       = rep_r;
    lcol_s      = lcol_r;
    key_valid_s = 1'b0;
    key_code_s  = key_code_r;
    case (state_r)
      ST_SCAN: begin
        if (dwell_r == DW'(SCAN_DIV - 1)) begin
          dwell_s = '0;
          if (single_low(col)) begin
            // keep driving this row while the press is qualified
            lcol_s  = col;
            cnt_s   = '0;
            state_s = ST_DEBOUNCE;
          end else begin
            ridx_s = ridx_r + 2'd1;
          end
        end else begin
          dwell_s = dwell_r + DW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (col != lcol_r) begin
          state_s = ST_SCAN;
          ridx_s  = ridx_r + 2'd1;
          dwell_s = '0;
        end else if (cnt_r == CW'(DEBOUNCE_CNT - 1)) begin
          key_valid_s = 1'b1;
          key_code_s  = key_map(ridx_r, low_pos(lcol_r));
          rep_s       = '0;
          state_s     = ST_HOLD;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_HOLD: begin
        if (col == 4'hF) begin
          cnt_s   = '0;
          state_s = ST_RELEASE;
        end else if (REPEAT_ON && (rep_r == RW'(REPEAT_CNT - 1))) begin
          key_valid_s = 1'b1;
          rep_s       = '0;
        end else begin
          rep_s = rep_r + RW'(1);
        end
      end
      ST_RELEASE: begin
        if (col != 4'hF) begin
          cnt_s = '0;
        end else if (cnt_r == CW'(DEBOUNCE_CNT - 1)) begin
          state_s = ST_SCAN;
          ridx_s  = 2'd0;
          dwell_s = '0;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = ST_SCAN;
        ridx_s  = 2'd0;
        dwell_s = '0;
        cnt_s   = '0;
      end
    endcase
  end

  // Scanner state registers; row drive is registered from the next row index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_SCAN;
      ridx_r      <= 2'd0;
      dwell_r     <= '0;
      cnt_r       <= '0;
      rep_r       <= '0;
      lcol_r      <= 4'hF;
      row_r       <= 4'b1110;
      key_valid_r <= 1'b0;
      key_code_r  <= 4'h0;
    end else begin
      state_r     <= state_s;
      ridx_r      <= ridx_s;
      dwell_r     <= dwell_s;
      cnt_r       <= cnt_s;
      rep_r       <= rep_s;
      lcol_r      <= lcol_s;
      row_r       <= ~(4'b0001 << ridx_s);
      key_valid_r <= key_valid_s;
      key_code_r  <= key_code_s;
    end
  end

  // Entry buffer update: clear has priority over the key strobe.
  always_comb begin
    code_s      = code_r;
    digit_cnt_s = digit_cnt_r;
    if (clear) begin
      code_s      = 16'h0000;
      digit_cnt_s = 3'd0;
    end else if (key_valid_r) begin
      if (key_code_r <= 4'd9) begin
        if (digit_cnt_r < 3'd4) begin
          code_s      = {code_r[11:0], key_code_r};
          digit_cnt_s = digit_cnt_r + 3'd1;
        end else begin
          code_s      = code_r;
          digit_cnt_s = digit_cnt_r;
        end
      end else if (key_code_r == 4'hE) begin
        // backspace drops the newest digit
        code_s = {4'h0, code_r[15:4]};
        if (digit_cnt_r != 3'd0) begin
          digit_cnt_s = digit_cnt_r - 3'd1;
        end else begin
          digit_cnt_s = digit_cnt_r;
        end
      end else begin
        code_s      = code_r;
        digit_cnt_s = digit_cnt_r;
      end
    end else begin
      code_s      = code_r;
      digit_cnt_s = digit_cnt_r;
    end
  end

  // Entry buffer registers; code_full tracks the next digit count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_r      <= 16'h0000;
      digit_cnt_r <= 3'd0;
      code_full_r <= 1'b0;
    end else begin
      code_r      <= code_s;
      digit_cnt_r <= digit_cnt_s;
      code_full_r <= (digit_cnt_s == 3'd4);
    end
  end

  assign row       = row_r;
  assign key_valid = key_valid_r;
  assign key_code  = key_code_r;
  assign code      = code_r;
  assign digit_cnt = digit_cnt_r;
  assign code_full = code_full_r;

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: keypad_entry bench with a physical keypad model, directed
// scenarios and randomized presses checked against a digit-list entry model.
module tb_keypad_entry;

  logic        clk;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        clear;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] code;
  logic [2:0]  digit_cnt;
  logic        code_full;

  keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_CNT(8), .REPEAT_CNT(32)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .clear(clear),
    .key_valid(key_valid), .key_code(key_code), .code(code),
    .digit_cnt(digit_cnt), .code_full(code_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // keys[r] bit c set = key at row r, column c is held down
  logic [3:0] keys [4];
  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  // Passive matrix: a driven-low row pulls down the columns of its held keys.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (row[r] == 1'b0) col = col & ~keys[r];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int kvq[$];
  logic [3:0] digits[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (key_valid === 1'b1) kvq.push_back(cyc);
  endtask

  function automatic int exp_pulses(input int held);
`ifdef KEYPAD_AUTO_REPEAT_EN
    return 1 + held / 32;
`else
    return 1;
`endif
  endfunction

  function automatic logic [15:0] model_code();
    logic [15:0] v;
    v = 16'h0000;
    foreach (digits[i]) v = {v[11:0], digits[i]};
    return v;
  endfunction

  task automatic apply_key(input logic [3:0] k);
    if (k <= 4'd9) begin
      if (digits.size() < 4) digits.push_back(k);
    end else if (k == 4'hE) begin
      if (digits.size() > 0) void'(digits.pop_back());
    end
  endtask

  task automatic check_buf(input string tag);
    check({tag, "_code"}, code, model_code());
    check({tag, "_cnt"}, digit_cnt, digits.size());
    check({tag, "_full"}, code_full, digits.size() == 4);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    digits.delete();
    check_buf("clear");
  endtask

  task automatic wait_row(input logic [3:0] target);
    int n;
    n = 0;
    while (row == target && n < 64) begin tick(); n++; end
    while (row != target && n < 64) begin tick(); n++; end
    check("wait_row", row, target);
  endtask

  // Press key (r,c), hold `hold` cycles past acceptance, release, compare.
  task automatic press_key(input int r, input int c, input int hold);
    int waited;
    int n;
    logic [3:0] k;
    k = kmap[r*4 + c];
    kvq.delete();
    keys[r] = 4'(4'b0001 << c);
    waited = 0;
    while (kvq.size() == 0 && waited < 120) begin tick(); waited++; end
    if (kvq.size() == 0) begin
      check("accept_timeout", 32'd0, 32'd1);
      keys[r] = 4'h0;
      repeat (30) tick();
    end else begin
      repeat (hold) tick();
      keys[r] = 4'h0;
      repeat (30) tick();
      n = exp_pulses(hold);
      check("pulse_count", kvq.size(), n);
      check("key_code", key_code, k);
      repeat (n) apply_key(k);
      check_buf("press");
    end
  endtask

  initial begin
    int c0, first1, v, held, n;
    rst = 1'b1;
    clear = 1'b0;
    for (int r = 0; r < 4; r++) keys[r] = 4'h0;
    #2 rst = 1'b0;

    // reset held while the row-0 columns toggle
    for (int i = 0; i < 8; i++) begin
      keys[0] = 4'($urandom);
      tick();
      check("rst_row", row, 4'b1110);
      check("rst_kv", key_valid, 1'b0);
      check("rst_code", code, 16'h0000);
      check("rst_cnt", digit_cnt, 3'd0);
    end
    check("rst_kcode", key_code, 4'h0);
    check("rst_full", code_full, 1'b0);

    // release reset with key 5 down; first row change 4 cycles later
    keys[0] = 4'h0;
    keys[1] = 4'b0010;
    kvq.delete();
    rst = 1'b1;
    c0 = cyc;
    repeat (3) begin tick(); check("row_hold", row, 4'b1110); end
    tick();
    check("row_step", row, 4'b1101);
    first1 = cyc;
    n = 0;
    while (kvq.size() == 0 && n < 60) begin tick(); n++; end
    check("key5_accept", kvq.size() > 0, 1'b1);
    if (kvq.size() > 0) begin
      // sample on the 4th cycle of row 1, strobe 9 cycles after it
      check("key5_latency", kvq[0], first1 + 3 + 9);
      v = kvq[0];
      while (cyc < c0 + 100) tick();
      held = cyc - v;
      keys[1] = 4'h0;
      repeat (30) tick();
      n = exp_pulses(held);
      check("key5_pulses", kvq.size(), n);
      check("key5_code", key_code, 4'h5);
      repeat (n) apply_key(4'h5);
      check_buf("key5");
    end

    // 1,2,3,4 fill the buffer, 5 ignored, E backspaces
    do_clear();
    press_key(0, 0, 3);
    press_key(0, 1, 3);
    press_key(0, 2, 3);
    press_key(1, 0, 3);
    check("full_code", code, 16'h1234);
    check("full_flag", code_full, 1'b1);
    press_key(1, 1, 3);
    check("ignore_code", code, 16'h1234);
    press_key(3, 0, 3);
    check("bs_code", code, 16'h0123);
    check("bs_cnt", digit_cnt, 3'd3);
    check("bs_full", code_full, 1'b0);

    // 5-cycle glitch on key 7 at the row-2 sample point
    wait_row(4'b1011);
    kvq.delete();
    keys[2] = 4'b0001;
    repeat (5) tick();
    keys[2] = 4'h0;
    repeat (30) tick();
    check("glitch_kv", kvq.size(), 0);
    check_buf("glitch");

    // two columns low on the same row
    kvq.delete();
    keys[1] = 4'b0011;
    repeat (60) tick();
    keys[1] = 4'h0;
    repeat (20) tick();
    check("twocol_kv", kvq.size(), 0);
    check_buf("twocol");

    // clear coincides with the cycle digit 9 would be added
    kvq.delete();
    keys[2] = 4'b0100;
    n = 0;
    while (kvq.size() == 0 && n < 120) begin tick(); n++; end
    check("nine_accept", kvq.size() > 0, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    keys[2] = 4'h0;
    digits.delete();
    repeat (30) tick();
    check("nine_pulses", kvq.size(), 1);
    check("nine_kcode", key_code, 4'h9);
    check("nine_code", code, 16'h0000);
    check("nine_cnt", digit_cnt, 3'd0);

    // reset in the middle of debouncing key 8
    press_key(1, 2, 2);
    wait_row(4'b1011);
    kvq.delete();
    keys[2] = 4'b0010;
    repeat (5) tick();
    rst = 1'b0;
    digits.delete();
    repeat (2) tick();
    check("mid_rst_row", row, 4'b1110);
    check("mid_rst_kv", key_valid, 1'b0);
    check("mid_rst_kcode", key_code, 4'h0);
    check_buf("mid_rst");
    keys[2] = 4'h0;
    rst = 1'b1;
    repeat (30) tick();
    check("mid_rst_nostrobe", kvq.size(), 0);

`ifdef KEYPAD_AUTO_REPEAT_EN
    // hold key 3 for 100 cycles past acceptance
    do_clear();
    press_key(0, 2, 100);
    check("rep_count", kvq.size(), 4);
    for (int i = 1; i < kvq.size(); i++) check("rep_gap", kvq[i] - kvq[i-1], 32);
    check("rep_code", code, 16'h3333);
`endif

    // randomized presses, occasional clears
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 7) == 0) do_clear();
      repeat ($urandom_range(0, 15)) tick();
      press_key($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 70));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Scans a 4x4 active-low matrix keypad, debounces each keypress and emits one strobe per press with a 4-bit key code.
- Assembles up to four decimal digits into a 16-bit BCD code word. This is the input end of the code path; the 7-segment display controller is the output end.
- Its outputs feed the detonator control FSM as the A/confirm source and the 16-bit entered code.

Parameters:
- SCAN_DIV, 1000, clock cycles each row is driven (dwell); minimum 2.
- DEBOUNCE_CNT, 20000, consecutive stable cycles required for both press and release; minimum 1.
- REPEAT_CNT, 5000000, auto-repeat period in cycles (used only with KEYPAD_AUTO_REPEAT_EN).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- row  output 4  keypad row drive, active-low, one-hot-zero
- col  input  4  keypad column sense, active-low, externally pulled up
- clear  input  1  synchronous clear of the entry buffer, level, active-high
- key_valid  output 1  one-cycle pulse per accepted press
- key_code  output 4  code of the last accepted key, held until the next press
- code  output 16  entered digits; newest digit in [3:0]
- digit_cnt  output 3  number of stored digits, 0..4
- code_full  output 1  high when digit_cnt==4

Behaviour:
- Reset (rst=0, asynchronous):
  - row=4'b1110, row index=0, state=SCAN.
  - key_valid=0, key_code=0, code=0, digit_cnt=0, code_full=0.
  - All counters cleared.
- Reset asserted mid-operation aborts any press or debounce in progress; no key_valid is emitted.
- row = ~(4'b0001 << ridx). ridx advances 0→1→2→3→0 every SCAN_DIV cycles, only in SCAN.
- Key map is row r, column c where c = position of the single 0 bit in col:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E,0,F,D
- FSM:
  - SCAN: col is sampled on the last dwell cycle of each row.
    - If col has exactly one 0 bit: latch ridx and col, go to DEBOUNCE; the row stays driven.
    - If col==4'hF, or col has two or more 0 bits: no action, the scan continues.
  - DEBOUNCE: counts cycles while col equals the latched value.
    - Any mismatch returns to SCAN at the next row.
    - When the count reaches DEBOUNCE_CNT: key_valid=1 for exactly one cycle, key_code is updated in the same cycle, go to HOLD.
  - HOLD: stays while col≠4'hF. When col==4'hF, go to RELEASE.
  - RELEASE: requires DEBOUNCE_CNT consecutive cycles of col==4'hF, then go to SCAN with ridx=0.
    - Any non-F value restarts the count and stays in RELEASE; no new strobe is produced.
- Latency: the sample is taken in cycle t; key_valid is high in cycle t+DEBOUNCE_CNT+1.
- Entry buffer acts on the cycle after key_valid:
  - Digit 0–9 with digit_cnt<4: code={code[11:0],key}, digit_cnt+1.
  - Digit with digit_cnt==4: ignored, no wrap.
  - Key E (backspace): code={4'h0,code[15:4]}; digit_cnt-1 if digit_cnt>0, else no change.
  - Keys A, B, C, D, F: reported on key_code only; the buffer is unchanged.
- clear: code=0, digit_cnt=0 on the next edge. clear wins over a simultaneous buffer update. clear does not affect the scan FSM or key_code.
- code_full is registered: it equals (digit_cnt==4) and updates in the same cycle as digit_cnt.

Optional Feature:
- KEYPAD_AUTO_REPEAT_EN defined:
  - In HOLD, after REPEAT_CNT cycles held, key_valid pulses again with the same key_code.
  - It then repeats every REPEAT_CNT cycles until release.
  - Repeats feed the entry buffer like new presses.
- Not defined: exactly one key_valid per press, regardless of hold time.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_CNT=32):
- Hold rst=0 with col toggling → row=1110, key_valid=0, code=0, digit_cnt=0 throughout; after release, the first row change occurs 4 cycles later.
- Press key 5 (col=4'b1101 while row=1101) and hold for 100 cycles → exactly one key_valid, key_code=5, delivered 9 cycles after the sample; then code=0x0005, digit_cnt=1.
- Press 1,2,3,4,5 then E, each with a clean release → code=0x1234 and code_full=1 after 4; the 5 is ignored; after E, code=0x0123, digit_cnt=3, code_full=0.
- 5-cycle col glitch on key 7; separately, two columns low at once → no key_valid, code unchanged.
- Pulse clear in the same cycle the buffer would add digit 9 → code=0, digit_cnt=0; rst=0 in the middle of DEBOUNCE → no strobe, reset values restored.
- With KEYPAD_AUTO_REPEAT_EN, hold key 3 for 100 cycles after acceptance → 4 key_valid pulses total, spaced 32 cycles apart; code=0x3333.
